// File: rtl/fabric_config_loader.sv
// Streaming config loader: assembles CFG_BITS from little-end-first words in a shadow
// register and commits it atomically to cfg_out, reporting errors on a sticky latch.
module fabric_config_loader #(
    parameter int unsigned CFG_BITS   = 16,
    parameter int unsigned WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_WIDTH-1:0] in_data,
    output logic [CFG_BITS-1:0]   cfg_out,
    output logic                  cfg_valid,
    output logic                  busy,
    output logic                  error_valid,
    output logic [15:0]           error_code
);

    localparam int unsigned NUM_WORDS = (CFG_BITS + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int unsigned LAST_LO   = (NUM_WORDS - 1) * WORD_WIDTH;
    localparam int unsigned LAST_BITS = CFG_BITS - LAST_LO;
    localparam int unsigned WCNT_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    localparam logic [WCNT_W-1:0]     LAST_IDX   = WCNT_W'(NUM_WORDS - 1);
    localparam logic [WORD_WIDTH-1:0] VALID_MASK = {WORD_WIDTH{1'b1}} >> (WORD_WIDTH - LAST_BITS);

    localparam logic [15:0] ERR_PAD_NONZERO = 16'd16;
    localparam logic [15:0] ERR_LOAD_ABORT  = 16'd264;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_LOAD = 1'b1;

    logic                state_q, state_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [CFG_BITS-1:0] shadow_q, shadow_d;
    logic [CFG_BITS-1:0] cfg_q, cfg_d;
    logic                cvalid_q, cvalid_d;
    logic                err_v_q, err_v_d;
    logic [15:0]         err_code_q, err_code_d;
    logic [CFG_BITS-1:0] commit_vec;
    logic                err_pad, err_abort;

    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        shadow_d   = shadow_q;
        cfg_d      = cfg_q;
        cvalid_d   = cvalid_q;
        err_pad    = 1'b0;
        err_abort  = 1'b0;
        commit_vec = shadow_q;
        commit_vec[LAST_LO +: LAST_BITS] = in_data[LAST_BITS-1:0];

        case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    state_d = ST_LOAD;
                    wcnt_d  = '0;
                end
            end
            ST_LOAD: begin
                // Restart outranks a same-cycle handshake; that word is dropped.
                if (cfg_start) begin
                    wcnt_d    = '0;
                    err_abort = 1'b1;
                end else if (in_valid) begin
                    if (wcnt_q == LAST_IDX) begin
                        cfg_d    = commit_vec;
                        cvalid_d = 1'b1;
                        state_d  = ST_IDLE;
                        wcnt_d   = '0;
                        err_pad  = |(in_data & ~VALID_MASK);
                    end else begin
                        for (int i = 0; i < int'(NUM_WORDS) - 1; i++) begin
                            if (wcnt_q == WCNT_W'(i)) begin
                                shadow_d[i*WORD_WIDTH +: WORD_WIDTH] = in_data;
                            end
                        end
                        wcnt_d = wcnt_q + WCNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // First error wins and sticks; lower code has priority within a cycle.
    always_comb begin
        err_v_d    = err_v_q;
        err_code_d = err_code_q;
        if (!err_v_q) begin
            if (err_pad) begin
                err_v_d    = 1'b1;
                err_code_d = ERR_PAD_NONZERO;
            end else if (err_abort) begin
                err_v_d    = 1'b1;
                err_code_d = ERR_LOAD_ABORT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wcnt_q     <= '0;
            shadow_q   <= '0;
            cfg_q      <= '0;
            cvalid_q   <= 1'b0;
            err_v_q    <= 1'b0;
            err_code_q <= '0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            shadow_q   <= shadow_d;
            cfg_q      <= cfg_d;
            cvalid_q   <= cvalid_d;
            err_v_q    <= err_v_d;
            err_code_q <= err_code_d;
        end
    end

    assign in_ready    = (state_q == ST_LOAD);
    assign busy        = (state_q == ST_LOAD);
    assign cfg_out     = cfg_q;
    assign cfg_valid   = cvalid_q;
    assign error_valid = err_v_q;
    assign error_code  = err_code_q;

endmodule

// File: tb/tb_fabric_config_loader.sv
// Self-checking bench for fabric_config_loader (CFG_BITS=40, WORD_WIDTH=32) against a
// queue-based reference model; directed plan steps followed by a random phase.
module tb_fabric_config_loader;

    localparam int unsigned CFG = 40;
    localparam int unsigned WW  = 32;
    localparam int unsigned NW  = (CFG + WW - 1) / WW;

    logic            clk = 1'b0;
    logic            rst, cfg_start, in_valid, in_ready;
    logic [WW-1:0]   in_data;
    logic [CFG-1:0]  cfg_out;
    logic            cfg_valid, busy, error_valid;
    logic [15:0]     error_code;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit              m_load;
    logic [WW-1:0]   m_words[$];
    logic [CFG-1:0]  m_cfg;
    bit              m_cvalid;
    bit              m_ev;
    logic [15:0]     m_ec;

    fabric_config_loader #(.CFG_BITS(CFG), .WORD_WIDTH(WW)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_start  (cfg_start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .cfg_out    (cfg_out),
        .cfg_valid  (cfg_valid),
        .busy       (busy),
        .error_valid(error_valid),
        .error_code (error_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic raise(input logic [15:0] code);
        if (!m_ev) begin
            m_ev = 1'b1;
            m_ec = code;
        end
    endtask

    task automatic model(input logic s, input logic v, input logic [WW-1:0] d, input logic r);
        logic [63:0] acc;
        if (r) begin
            m_load = 0; m_words.delete(); m_cfg = '0; m_cvalid = 0; m_ev = 0; m_ec = '0;
        end else if (!m_load) begin
            if (s) begin
                m_load = 1;
                m_words.delete();
            end
        end else if (s) begin
            m_words.delete();
            raise(16'd264);
        end else if (v) begin
            m_words.push_back(d);
            if (m_words.size() == NW) begin
                acc = '0;
                for (int i = 0; i < int'(NW); i++) acc |= 64'(m_words[i]) << (i * WW);
                m_cfg = acc[CFG-1:0];
                m_cvalid = 1;
                m_load = 0;
                if ((m_words[NW-1] >> (CFG - (NW - 1) * WW)) != 0) raise(16'd16);
                m_words.delete();
            end
        end
    endtask

    // One clock: drive inputs, advance model, sample #1 after the edge and compare.
    task automatic step(input logic s, input logic v, input logic [WW-1:0] d, input logic r);
        cfg_start = s; in_valid = v; in_data = d; rst = r;
        model(s, v, d, r);
        @(posedge clk);
        #1;
        check("cfg_out", 64'(cfg_out), 64'(m_cfg));
        check("cfg_valid", 64'(cfg_valid), 64'(m_cvalid));
        check("busy", 64'(busy), 64'(m_load));
        check("in_ready", 64'(in_ready), 64'(m_load));
        check("error_valid", 64'(error_valid), 64'(m_ev));
        check("error_code", 64'(error_code), 64'(m_ec));
    endtask

    initial begin
        logic [WW-1:0] d;
        rst = 1; cfg_start = 0; in_valid = 0; in_data = '0;
        step(0, 0, '0, 1);
        check("reset_cfg_out", 64'(cfg_out), 64'h0);
        check("reset_in_ready", 64'(in_ready), 64'h0);

        // 1: basic load
        step(1, 0, '0, 0);
        step(0, 1, 32'hDEADBEEF, 0);
        step(0, 1, 32'h000000A5, 0);
        check("t1_cfg", 64'(cfg_out), 64'hA5DEADBEEF);
        check("t1_busy", 64'(busy), 64'h0);

        // 2: gaps keep old value until commit
        step(1, 0, '0, 0);
        step(0, 1, 32'h11111111, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 32'hFFFFFFFF, 0);
            check("t2_gap_cfg", 64'(cfg_out), 64'hA5DEADBEEF);
        end
        step(0, 1, 32'h00000022, 0);
        check("t2_cfg", 64'(cfg_out), 64'h2211111111);

        // 3: nonzero padding
        step(1, 0, '0, 0);
        step(0, 1, 32'hDEADBEEF, 0);
        step(0, 1, 32'h000001A5, 0);
        check("t3_cfg", 64'(cfg_out), 64'hA5DEADBEEF);
        check("t3_code", 64'(error_code), 64'd16);

        // 4: restart, then sticky abort code
        step(0, 0, '0, 1);
        step(1, 0, '0, 0);
        step(0, 1, 32'h12345678, 0);
        step(1, 0, '0, 0);
        step(0, 1, 32'hCAFEF00D, 0);
        step(0, 1, 32'h00000033, 0);
        check("t4_code", 64'(error_code), 64'd264);
        check("t4_cfg", 64'(cfg_out), 64'h33CAFEF00D);
        step(1, 0, '0, 0);
        step(0, 1, 32'h0, 0);
        step(0, 1, 32'hFF00, 0);
        check("t4_sticky", 64'(error_code), 64'd264);

        // 5: idle input ignored; same-cycle start drops the word
        for (int i = 0; i < 5; i++) step(0, 1, 32'h55AA55AA, 0);
        check("t5_idle_cfg", 64'(cfg_out), 64'h0000000000);
        step(1, 1, 32'h77777777, 0);
        step(0, 1, 32'h01020304, 0);
        step(0, 1, 32'h00000005, 0);
        check("t5_cfg", 64'(cfg_out), 64'h0501020304);

        // 6: reset mid-load, then a clean load
        step(1, 0, '0, 0);
        step(0, 1, 32'h9ABCDEF0, 0);
        step(0, 1, 32'h000000EE, 1);
        check("t6_rst_cfg", 64'(cfg_out), 64'h0);
        check("t6_rst_ev", 64'(error_valid), 64'h0);
        step(1, 0, '0, 0);
        step(0, 1, 32'h0BADF00D, 0);
        step(0, 1, 32'h000000C3, 0);
        check("t6_cfg", 64'(cfg_out), 64'hC30BADF00D);

        // Random phase against the model
        for (int i = 0; i < 400; i++) begin
            d = $urandom;
            if ($urandom_range(0, 3) != 0) d &= 32'h000000FF;
            if ($urandom_range(0, 1) != 0 && (i % 7) != 0) d = $urandom;
            step($urandom_range(0, 11) == 0, $urandom_range(0, 9) < 7, d,
                 $urandom_range(0, 99) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fabric_config_loader.md
# fabric_config_loader

Streaming configuration loader that assembles a switch's `cfg_route_table` (or any flat config vector) from a sequence of fixed-width config words and commits it atomically. It sits between the fabric configuration bus and a `fabric_switch` (or other configurable fabric block), driving that block's config input. Errors are reported on the same sticky `error_valid`/`error_code` interface the fabric blocks use.

## Interface
- `CFG_BITS`, default 16: width of the committed config vector (1..1024).
- `WORD_WIDTH`, default 32: width of each incoming config word (1..64).
- `NUM_WORDS`, localparam = ceil(`CFG_BITS`/`WORD_WIDTH`): words per load.

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cfg_start`  in  1  begin a load (level sampled each edge).
- `in_valid`  in  1  config word valid.
- `in_ready`  out  1  loader accepts a word.
- `in_data`  in  `WORD_WIDTH`  config word.
- `cfg_out`  out  `CFG_BITS`  committed config vector, registered.
- `cfg_valid`  out  1  at least one load has committed since reset.
- `busy`  out  1  load in progress.
- `error_valid`  out  1  sticky error flag.
- `error_code`  out  16  code of the first error latched.

## Operation
- States are IDLE and LOAD. A `shadow` register of width `CFG_BITS` and a word counter `wcnt` (0..`NUM_WORDS`-1) back them.
- IDLE:
  - `in_ready`=0, `busy`=0.
  - `cfg_start`=1 moves the loader to LOAD and sets `wcnt`=0. `in_valid` is ignored.
- LOAD:
  - `in_ready`=1, `busy`=1. A handshake is `in_valid && in_ready`.
  - On a handshake with `wcnt`<`NUM_WORDS`-1: `in_data` is written into `shadow[wcnt*WORD_WIDTH +: WORD_WIDTH]` and `wcnt` increments.
  - On a handshake with `wcnt`=`NUM_WORDS`-1 (the last word): `cfg_out` is loaded from `shadow` merged with the valid low bits of `in_data`, `cfg_valid` is set to 1, and the loader returns to IDLE.
  - Word 0 supplies `cfg_out[WORD_WIDTH-1:0]`. Words are little-end-first.
- Padding:
  - The last word carries `CFG_BITS - (NUM_WORDS-1)*WORD_WIDTH` valid bits. Its upper bits are padding.
  - Nonzero padding is discarded. The commit still happens, and error code 16 (CFG_LOADER_PAD_NONZERO) is raised.
- Restart:
  - `cfg_start`=1 while in LOAD restarts the load: `wcnt` returns to 0 and no handshake is accepted that cycle.
  - `cfg_out` is unchanged.
  - Error code 264 (RT_LOADER_LOAD_ABORT) is raised.
- `cfg_out` changes only at a commit edge. Partial loads never become visible.
- Error latch:
  - When `error_valid`=0 and an error is detected, `error_valid` is set to 1 and `error_code` takes the detected code.
  - If several errors are detected in the same cycle, the lowest code wins.
  - Once set, the latch holds until `rst`. Later errors are ignored. The loader keeps operating while an error is latched.

## Timing
- Reset values: IDLE, `wcnt`=0, `shadow`=0, `cfg_out`=0, `cfg_valid`=0, `busy`=0, `in_ready`=0, `error_valid`=0, `error_code`=0.
- Outputs:
  - `in_ready` and `busy` are decoded from the state register.
  - `in_ready` has no combinational path from `in_valid` or `cfg_start`.
- `cfg_start` sampled high at edge N makes `in_ready`=1 from N+1. The first handshake is possible at edge N+1.
- One word is accepted per cycle. The minimum load is `NUM_WORDS` cycles after the start edge.
- For the last handshake at edge M:
  - `cfg_out`, `cfg_valid` and any padding error are visible after M.
  - `in_ready`=0 and `busy`=0 after M.
  - A new `cfg_start` can be sampled at edge M+1.
- When `cfg_start`=1 and a handshake occur in the same LOAD cycle, the restart wins and the word is dropped.
- `rst` asserted mid-load discards `shadow` and zeros `cfg_out` and `cfg_valid`.
- `rst` dominates every other input in the same cycle.
- `NUM_WORDS`=1: the first handshake is the commit.

## Test plan
Unless stated otherwise, `CFG_BITS`=40 and `WORD_WIDTH`=32, so `NUM_WORDS`=2 and the last word has 8 valid bits.

1. **Basic load.** Pulse start, then send words 0xDEADBEEF and 0x000000A5 back-to-back.
   - Cycle after the second handshake: `cfg_out`=40'hA5DEADBEEF, `cfg_valid`=1, `busy`=0, `error_valid`=0.
2. **Gaps and atomic commit.** After test 1, start a new load.
   - Send word 0x11111111, hold `in_valid`=0 for 3 cycles, then send 0x00000022.
   - Throughout the gap: `cfg_out` stays 40'hA5DEADBEEF.
   - After the commit: `cfg_out`=40'h2211111111.
3. **Nonzero padding.** Send words 0xDEADBEEF and 0x000001A5.
   - `cfg_out`=40'hA5DEADBEEF, `error_valid`=1, `error_code`=16.
4. **Restart, then sticky error.** Start, send 0x12345678, raise `cfg_start` again, then send 0xCAFEF00D and 0x00000033.
   - `error_code`=264.
   - `cfg_out`=40'h33CAFEF00D; the first word is lost.
   - A following padding error leaves `error_code` at 264.
5. **Idle input and same-cycle start.**
   - In IDLE with `in_valid`=1 for 5 cycles: `in_ready`=0 and nothing changes.
   - `cfg_start` and `in_valid` high in the same cycle: the word is not accepted.
6. **Reset mid-load.** Start, send one word, assert `rst` for one cycle.
   - All outputs return to their reset values; `in_ready`=0.
   - A subsequent full load commits correctly.
